decim_mac_scheduler: RTL and testbench
======================================

// Module: decim_mac_scheduler
// PURPOSE
//  Round-robin scheduler sharing one FIR multiply-accumulate engine among the
//  cascaded PDM decimation stages (stage 0 = PDM-rate stage, deepest = audio-rate).
//  Latches each stage's sample-valid pulse as a pending request and grants the engine to one stage at a time.
//  Issues a start pulse and stage index, then waits for the engine's done pulse.
//  Sits between the decimator stage valid strobes and the shared MAC datapath, all on clk_in.
// PARAMETERS
//  NUM_STAGES      4    number of requesting decimator stages (2..8)
//  TIMEOUT_CYCLES  1024 max cycles in WAIT before abort (used only with DECIM_SCHED_TIMEOUT_EN)
// PORTS
//  clk_in          in   1             system audio clock; all logic on rising edge
//  rst_in          in   1             synchronous, active-high reset
//  req_in          in   NUM_STAGES    per-stage single-cycle "sample ready" pulse
//  mac_done_in     in   1             single-cycle pulse: engine finished current job
//  overrun_clr_in  in   1             clears overrun_out sticky bits
//  mac_start_out   out  1             single-cycle pulse: begin job for mac_stage_out
//  mac_stage_out   out  $clog2(NUM_STAGES)  stage index of current/last grant
//  busy_out        out  1             high in START and WAIT states
//  pending_out     out  NUM_STAGES    registered pending-request vector
//  overrun_out     out  NUM_STAGES    sticky: request arrived while already pending
//  timeout_out     out  1             sticky: engine timeout (0 when feature compiled out)
// BEHAVIOUR
//  Reset (rst_in=1 at edge): state=IDLE; mac_start_out=0; mac_stage_out=0; busy_out=0;
//   pending_out=0; overrun_out=0; timeout_out=0; last-grant pointer=NUM_STAGES-1.
//  Pending: bit i set at edge where req_in[i]=1. Bit i cleared at edge where IDLE grants i,
//   unless req_in[i]=1 in that same cycle (new request wins; stays 1, no overrun).
//  Overrun: req_in[i]=1 while pending_out[i]=1 and i not being granted this cycle ->
//   overrun_out[i] set; pending stays 1 (request merged, not queued). overrun_clr_in
//   clears all bits; a simultaneous new overrun event wins (bit set).
//  FSM states:
//   IDLE : if pending_out!=0, pick first set bit searching (ptr+1..ptr) mod NUM_STAGES;
//          register mac_stage_out=pick, ptr=pick, clear pending[pick], go START.
//   START: mac_start_out=1 for exactly this cycle; go WAIT.
//   WAIT : on mac_done_in=1 go IDLE. mac_done_in in IDLE/START ignored.
//  Latency: req_in[i] in cycle 0 with FSM idle -> pending in cycle 1 -> mac_start_out
//   high in cycle 2. Back-to-back: done in cycle d -> next mac_start_out in cycle d+2.
//  mac_start_out, busy_out, mac_stage_out are registered; mac_stage_out holds between grants.
//  Fairness: with all stages permanently pending, grants cycle 0,1,..,N-1,0,...
//  Reset mid-job (any state): immediate return to reset values; in-flight job abandoned,
//   late mac_done_in ignored.
//  Requests accepted in every state, including WAIT for the stage currently served.
// CONFIGURATION
//  DECIM_SCHED_TIMEOUT_EN defined: WAIT counts cycles from entry; if count reaches
//   TIMEOUT_CYCLES without mac_done_in -> go IDLE, set timeout_out (sticky, cleared
//   only by rst_in). mac_done_in in the same cycle as expiry counts as done (no timeout).
//  Not defined: no counter; WAIT lasts until mac_done_in; timeout_out tied 0.
// TESTING
//  1 Reset then req_in=4'b0001 cycle 0; done 5 cycles after start -> start in cycle 2,
//    mac_stage_out=0, busy_out high cycles 2..7, pending_out back to 0 at cycle 2.
//  2 req_in=4'b1111 one cycle, done 3 cycles after each start -> starts ordered stage
//    0,1,2,3; each start 2 cycles after prior done; overrun_out=0.
//  3 req_in[1] pulsed twice while stage 0 in WAIT -> overrun_out=4'b0010, stage 1
//    serviced once; overrun_clr_in pulse -> overrun_out=0.
//  4 req_in[2] pulse in the same cycle IDLE grants stage 2 -> pending_out[2] stays 1,
//    no overrun, stage 2 granted again after done.
//  5 rst_in asserted in WAIT, mac_done_in pulsed next cycle -> all outputs at reset
//    values, no mac_start_out afterward until new req_in.
//  6 (TIMEOUT_EN, TIMEOUT_CYCLES=16) grant with no done -> FSM IDLE 16 cycles after
//    WAIT entry, timeout_out=1; next pending stage then started.

Source files
------------

// File: rtl/decim_mac_scheduler.sv
// Round-robin scheduler granting one shared FIR MAC engine to cascaded PDM decimation stages.
// Optional WAIT watchdog enabled by defining DECIM_SCHED_TIMEOUT_EN.
module decim_mac_scheduler #(
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_STAGES-1:0]         req_in,
    input  logic                          mac_done_in,
    input  logic                          overrun_clr_in,
    output logic                          mac_start_out,
    output logic [$clog2(NUM_STAGES)-1:0] mac_stage_out,
    output logic                          busy_out,
    output logic [NUM_STAGES-1:0]         pending_out,
    output logic [NUM_STAGES-1:0]         overrun_out,
    output logic                          timeout_out
);

    localparam int unsigned SW = $clog2(NUM_STAGES);

    if (NUM_STAGES < 2 || NUM_STAGES > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("decim_mac_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_start;
    logic                  r_busy;
    logic [SW-1:0]         r_stage;
    logic [SW-1:0]         r_ptr;
    logic [NUM_STAGES-1:0] r_pending;
    logic [NUM_STAGES-1:0] r_overrun;

    logic                  w_found;
    logic [SW-1:0]         w_pick;
    logic                  w_grant;
    logic [NUM_STAGES-1:0] w_grant_vec;
    logic [NUM_STAGES-1:0] w_ov_set;

`ifdef DECIM_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]         r_wait_cnt;
    logic                  r_timeout;
    logic                  w_to_expire;
`endif

    // Round-robin search: first pending stage after the last grant, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
            if (!w_found && r_pending[SW'((32'(r_ptr) + k) % NUM_STAGES)]) begin
                w_found = 1'b1;
                w_pick  = SW'((32'(r_ptr) + k) % NUM_STAGES);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
`ifdef DECIM_SCHED_TIMEOUT_EN
        w_to_expire = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done_in) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef DECIM_SCHED_TIMEOUT_EN
                // A done arriving on the expiry cycle takes priority over the abort.
                else if (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_to_expire = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_grant_vec = w_grant ? (NUM_STAGES'(1) << w_pick) : '0;
    assign w_ov_set    = req_in & r_pending & ~w_grant_vec;

    // A request landing on its own grant cycle re-arms the pending bit instead of overrunning.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_stage   <= '0;
            r_ptr     <= SW'(NUM_STAGES - 1);
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_start   <= (w_state_nxt == S_START);
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_grant) begin
                r_stage <= w_pick;
                r_ptr   <= w_pick;
            end
            r_pending <= req_in | (r_pending & ~w_grant_vec);
            r_overrun <= (overrun_clr_in ? '0 : r_overrun) | w_ov_set;
        end
    end

`ifdef DECIM_SCHED_TIMEOUT_EN
    // Counter is zero on the first WAIT cycle because START always precedes WAIT.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + CW'(1) : '0;
            if (w_to_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_out = r_timeout;
`else
    assign timeout_out = 1'b0;
`endif

    assign mac_start_out = r_start;
    assign mac_stage_out = r_stage;
    assign busy_out      = r_busy;
    assign pending_out   = r_pending;
    assign overrun_out   = r_overrun;

endmodule

// File: tb/tb_decim_mac_scheduler.sv
// Bench for decim_mac_scheduler: directed scenarios plus randomized traffic against a
// transaction-level reference model of the round-robin scheduler and a simple engine.
module tb_decim_mac_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [3:0] req_in;
    logic       mac_done_in;
    logic       overrun_clr_in;
    logic       mac_start_out;
    logic [1:0] mac_stage_out;
    logic       busy_out;
    logic [3:0] pending_out;
    logic [3:0] overrun_out;
    logic       timeout_out;

    decim_mac_scheduler #(
        .NUM_STAGES    (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_in        (req_in),
        .mac_done_in   (mac_done_in),
        .overrun_clr_in(overrun_clr_in),
        .mac_start_out (mac_start_out),
        .mac_stage_out (mac_stage_out),
        .busy_out      (busy_out),
        .pending_out   (pending_out),
        .overrun_out   (overrun_out),
        .timeout_out   (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Reference model: phase 0 idle, 1 start, 2 engine working.
    int       m_phase;
    bit [3:0] m_pend;
    bit [3:0] m_ov;
    int       m_last;
    int       m_stage;
    bit       m_to;
    int       m_age;

    // Engine model: cycle on which it answers (-1 = never).
    int eng_fixed    = 3;
    int eng_hang_pct = 0;
    int eng_done_cyc = -1;

    int st_cyc[$];
    int st_stage[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pend  = '0;
        m_ov    = '0;
        m_last  = N - 1;
        m_stage = 0;
        m_to    = 1'b0;
        m_age   = 0;
    endtask

    task automatic model_step(input logic [3:0] rq, input logic d, input logic c);
        int g;
        bit gi;
        bit ovset;
        g = -1;
        if (m_phase == 0) begin
            for (int k = 1; k <= N; k++) begin
                int s;
                s = (m_last + k) % N;
                if (g < 0 && m_pend[s]) g = s;
            end
        end
        case (m_phase)
            0: if (g >= 0) begin
                m_phase = 1;
                m_stage = g;
                m_last  = g;
            end
            1: begin
                m_phase = 2;
                m_age   = 0;
            end
            default: begin
                if (d) m_phase = 0;
                else begin
                    m_age++;
`ifdef DECIM_SCHED_TIMEOUT_EN
                    if (m_age == TO) begin
                        m_phase = 0;
                        m_to    = 1'b1;
                    end
`endif
                end
            end
        endcase
        for (int i = 0; i < N; i++) begin
            gi        = (g == i);
            ovset     = rq[i] && m_pend[i] && !gi;
            m_ov[i]   = (c ? 1'b0 : m_ov[i]) || ovset;
            m_pend[i] = rq[i] || (m_pend[i] && !gi);
        end
    endtask

    task automatic step(input logic [3:0] rq, input logic c, input logic r, input logic force_done);
        logic d;
        d              = force_done || (cyc == eng_done_cyc);
        req_in         = rq;
        mac_done_in    = d;
        overrun_clr_in = c;
        rst_in         = r;
        @(posedge clk_in);
        if (r) begin
            model_reset();
            eng_done_cyc = -1;
        end else begin
            model_step(rq, d, c);
        end
        cyc++;
        @(negedge clk_in);
        check("start",   32'(mac_start_out), 32'(m_phase == 1));
        check("busy",    32'(busy_out),      32'(m_phase != 0));
        check("stage",   32'(mac_stage_out), 32'(m_stage));
        check("pending", 32'(pending_out),   32'(m_pend));
        check("overrun", 32'(overrun_out),   32'(m_ov));
        check("timeout", 32'(timeout_out),   32'(m_to));
        if (m_phase == 1) begin
            if (eng_fixed > 0) eng_done_cyc = cyc + eng_fixed;
            else if (eng_fixed == 0) eng_done_cyc = -1;
            else if ($urandom_range(99) < 32'(eng_hang_pct)) eng_done_cyc = -1;
            else eng_done_cyc = cyc + int'($urandom_range(6, 1));
        end
        if (mac_start_out === 1'b1) begin
            st_cyc.push_back(cyc);
            st_stage.push_back(int'(mac_stage_out));
        end
        req_in         = '0;
        mac_done_in    = 1'b0;
        overrun_clr_in = 1'b0;
        rst_in         = 1'b0;
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        cyc = 0;
        st_cyc.delete();
        st_stage.delete();
    endtask

    initial begin
        int n_s1;
        int n_s2;
        int first2;
        int last2;
        rst_in         = 1'b1;
        req_in         = '0;
        mac_done_in    = 1'b0;
        overrun_clr_in = 1'b0;
        model_reset();
        @(negedge clk_in);

        // Single request, engine answers 5 cycles after start
        do_reset();
        check("rst_pending", 32'(pending_out), 32'h0);
        check("rst_busy",    32'(busy_out),    32'h0);
        eng_fixed = 5;
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        check("t1_pend_c1", 32'(pending_out), 32'h1);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("t1_start_c2", 32'(mac_start_out), 32'h1);
        check("t1_stage_c2", 32'(mac_stage_out), 32'h0);
        check("t1_pend_c2",  32'(pending_out),   32'h0);
        repeat (5) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("t1_busy_c7", 32'(busy_out), 32'h1);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("t1_idle_c8", 32'(busy_out), 32'h0);
        check("t1_nstart", 32'(st_cyc.size()), 32'd1);

        // All four stages at once, round-robin from stage 0
        do_reset();
        eng_fixed = 3;
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (24) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("t2_nstart", 32'(st_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < st_stage.size(); i++) begin
            check("t2_order", 32'(st_stage[i]), 32'(i));
            if (i > 0) check("t2_gap", 32'(st_cyc[i] - st_cyc[i-1]), 32'd5);
        end
        check("t2_overrun", 32'(overrun_out), 32'h0);

        // Repeated request on a pending stage while stage 0 is served
        do_reset();
        eng_fixed = 8;
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0, 1'b0);
        check("t3_overrun", 32'(overrun_out), 32'h2);
        repeat (20) step(4'b0000, 1'b0, 1'b0, 1'b0);
        n_s1 = 0;
        foreach (st_stage[i]) if (st_stage[i] == 1) n_s1++;
        check("t3_s1_once", 32'(n_s1), 32'd1);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t3_clr", 32'(overrun_out), 32'h0);

        // Request on the very cycle its stage is granted
        do_reset();
        eng_fixed = 3;
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        check("t4_start",   32'(mac_start_out), 32'h1);
        check("t4_stage",   32'(mac_stage_out), 32'h2);
        check("t4_pend",    32'(pending_out),   32'h4);
        check("t4_overrun", 32'(overrun_out),   32'h0);
        repeat (12) step(4'b0000, 1'b0, 1'b0, 1'b0);
        n_s2 = 0;
        first2 = -1;
        last2 = -1;
        foreach (st_stage[i]) if (st_stage[i] == 2) begin
            n_s2++;
            if (first2 < 0) first2 = st_cyc[i];
            last2 = st_cyc[i];
        end
        check("t4_s2_twice", 32'(n_s2), 32'd2);
        check("t4_regrant_cycle", 32'(last2 - first2), 32'd5);

        // Reset while the engine is working, late done afterwards
        do_reset();
        eng_fixed = 0;
        step(4'b1000, 1'b0, 1'b0, 1'b0);
        repeat (3) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("t5_busy_pre", 32'(busy_out), 32'h1);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        check("t5_rst_busy",  32'(busy_out),      32'h0);
        check("t5_rst_stage", 32'(mac_stage_out), 32'h0);
        check("t5_rst_pend",  32'(pending_out),   32'h0);
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        repeat (5) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("t5_no_start", 32'(st_cyc.size()), 32'd1);

        // Engine never answers; watchdog (if built) aborts, then next stage runs
        do_reset();
        eng_fixed = 0;
        step(4'b0101, 1'b0, 1'b0, 1'b0);
        repeat (18) step(4'b0000, 1'b0, 1'b0, 1'b0);
        eng_fixed = 2;
`ifdef DECIM_SCHED_TIMEOUT_EN
        check("t6_idle_c19", 32'(busy_out),    32'h0);
        check("t6_to_c19",   32'(timeout_out), 32'h1);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("t6_start_c20", 32'(mac_start_out), 32'h1);
        check("t6_stage_c20", 32'(mac_stage_out), 32'h2);
`else
        check("t6_busy_c19", 32'(busy_out),    32'h1);
        check("t6_to_c19",   32'(timeout_out), 32'h0);
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("t6_start_c21", 32'(mac_start_out), 32'h1);
        check("t6_stage_c21", 32'(mac_stage_out), 32'h2);
`endif
        repeat (6) step(4'b0000, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model
        do_reset();
        eng_fixed = -1;
`ifdef DECIM_SCHED_TIMEOUT_EN
        eng_hang_pct = 10;
`else
        eng_hang_pct = 0;
`endif
        for (int t = 0; t < 600; t++) begin
            logic [3:0] rq;
            for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(5) == 0);
            step(rq, ($urandom_range(15) == 0), ($urandom_range(249) == 0), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
